// File: rtl/uarch_pkg.sv
// Micro-architecture types shared by the issue stage, the execute pipes
// and their testbenches.
package uarch_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_MUL = 4'd1,
    OP_LW  = 4'd2,
    OP_SW  = 4'd3,
    OP_BEQ = 4'd4,
    OP_NOP = 4'd5
  } rv_uop;

endpackage

// File: rtl/mul_add_execute_unit.sv
// Execute pipe endpoint: single-cycle ADD and an iterative radix-2 shift-add
// MUL, broadcasting results on the completion bus.
module mul_add_execute_unit
  import uarch_pkg::*;
#(
  parameter int p_seq_num_bits = 5,
  parameter bit p_early_exit   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_val,
  output logic                      d_rdy,
  input  logic [31:0]               d_pc,
  input  logic [31:0]               d_op1,
  input  logic [31:0]               d_op2,
  input  logic [4:0]                d_waddr,
  input  rv_uop                     d_uop,
  input  logic [p_seq_num_bits-1:0] d_seq_num,
  output logic                      complete_val,
  output logic [p_seq_num_bits-1:0] complete_seq_num,
  output logic [4:0]                complete_waddr,
  output logic [31:0]               complete_wdata,
  output logic                      complete_wen
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] acc;
  logic [4:0]  count;

  logic [p_seq_num_bits-1:0] seq_q;
  logic [4:0]                waddr_q;
  logic                      wen_q;

  logic        accept;
  logic        is_add;
  logic        is_mul;
  logic        wen_in;
  logic        mul_short;
  logic [31:0] acc_nx;
  logic [31:0] b_nx;
  logic        fin;
  logic        unused_pc;

  assign unused_pc = ^d_pc;

  assign d_rdy  = !rst && (state != CALC);
  assign accept = d_val && d_rdy;

  always_comb begin
    is_add = 1'b0;
    is_mul = 1'b0;
    unique case (1'b1)
      (d_uop == OP_ADD): is_add = 1'b1;
      (d_uop == OP_MUL): is_mul = 1'b1;
      default: ;
    endcase
  end

  assign wen_in    = (d_waddr != 5'd0) && (is_add || is_mul);
  assign mul_short = p_early_exit && (d_op2 == 32'd0);

  always_comb begin
    acc_nx = b[0] ? acc + a : acc;
    b_nx   = b >> 1;
    fin    = (count == 5'd31) || (p_early_exit && (b_nx == 32'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      a                <= '0;
      b                <= '0;
      acc              <= '0;
      count            <= '0;
      seq_q            <= '0;
      waddr_q          <= '0;
      wen_q            <= 1'b0;
      complete_val     <= 1'b0;
      complete_seq_num <= '0;
      complete_waddr   <= '0;
      complete_wdata   <= '0;
      complete_wen     <= 1'b0;
    end else begin
      complete_val <= 1'b0;
      unique case (state)
        CALC: begin
          acc   <= acc_nx;
          a     <= a << 1;
          b     <= b_nx;
          count <= count + 5'd1;
          if (fin) begin
            state            <= DONE;
            complete_val     <= 1'b1;
            complete_wdata   <= acc_nx;
            complete_seq_num <= seq_q;
            complete_waddr   <= waddr_q;
            complete_wen     <= wen_q;
          end
        end
        default: begin
          if (accept) begin
            seq_q   <= d_seq_num;
            waddr_q <= d_waddr;
            wen_q   <= wen_in;
            if (is_mul) begin
              a     <= d_op1;
              b     <= d_op2;
              acc   <= '0;
              count <= '0;
            end
            if (is_mul && !mul_short) begin
              state <= CALC;
            end else begin
              // ADD, zero-multiplier MUL and unsupported ops finish now
              state            <= DONE;
              complete_val     <= 1'b1;
              complete_wdata   <= is_add ? d_op1 + d_op2 : 32'd0;
              complete_seq_num <= d_seq_num;
              complete_waddr   <= d_waddr;
              complete_wen     <= wen_in;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_execute_unit.sv
// Bench for mul_add_execute_unit: two instances (early exit off / on) checked
// against an arithmetic reference model with directed and random ops.
module tb_mul_add_execute_unit;
  import uarch_pkg::*;

  logic        clk;
  logic        rst;
  logic        d_val0;
  logic        d_val1;
  logic [31:0] d_pc;
  logic [31:0] d_op1;
  logic [31:0] d_op2;
  logic [4:0]  d_waddr;
  rv_uop       d_uop;
  logic [4:0]  d_seq_num;

  logic        rdy0, cv0, ce0;
  logic [4:0]  cs0, cw0;
  logic [31:0] cd0;
  logic        rdy1, cv1, ce1;
  logic [4:0]  cs1, cw1;
  logic [31:0] cd1;

  int total = 0;
  int bad   = 0;

  mul_add_execute_unit #(.p_seq_num_bits(5), .p_early_exit(1'b0)) dut0 (
    .clk(clk), .rst(rst), .d_val(d_val0), .d_rdy(rdy0),
    .d_pc(d_pc), .d_op1(d_op1), .d_op2(d_op2), .d_waddr(d_waddr),
    .d_uop(d_uop), .d_seq_num(d_seq_num),
    .complete_val(cv0), .complete_seq_num(cs0), .complete_waddr(cw0),
    .complete_wdata(cd0), .complete_wen(ce0)
  );

  mul_add_execute_unit #(.p_seq_num_bits(5), .p_early_exit(1'b1)) dut1 (
    .clk(clk), .rst(rst), .d_val(d_val1), .d_rdy(rdy1),
    .d_pc(d_pc), .d_op1(d_op1), .d_op2(d_op2), .d_waddr(d_waddr),
    .d_uop(d_uop), .d_seq_num(d_seq_num),
    .complete_val(cv1), .complete_seq_num(cs1), .complete_waddr(cw1),
    .complete_wdata(cd1), .complete_wen(ce1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input bit early, input rv_uop u,
                                input logic [31:0] op2);
    if (u != OP_MUL) return 1;
    if (!early) return 33;
    if (op2 == 32'd0) return 1;
    for (int i = 31; i >= 0; i--)
      if (op2[i]) return i + 2;
    return 1;
  endfunction

  function automatic logic [31:0] res_of(input rv_uop u,
                                         input logic [31:0] op1,
                                         input logic [31:0] op2);
    if (u == OP_ADD) return op1 + op2;
    if (u == OP_MUL) return op1 * op2;
    return 32'd0;
  endfunction

  function automatic logic wen_of(input rv_uop u, input logic [4:0] wa);
    return (wa != 5'd0) && (u == OP_ADD || u == OP_MUL);
  endfunction

  task automatic do_op(input bit e0, input bit e1, input rv_uop u,
                       input logic [31:0] op1, input logic [31:0] op2,
                       input logic [4:0] wa, input logic [4:0] sq);
    int n, l0, l1, lm;
    logic [31:0] r;
    logic w;
    n = 0;
    @(negedge clk);
    while (!((!e0 || rdy0) && (!e1 || rdy1)) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("issue_wait", n < 50, 1'b1);
    d_pc = $urandom();
    d_uop = u; d_op1 = op1; d_op2 = op2; d_waddr = wa; d_seq_num = sq;
    d_val0 = e0; d_val1 = e1;
    @(posedge clk);
    #1 d_val0 = 1'b0; d_val1 = 1'b0;
    l0 = lat_of(1'b0, u, op2);
    l1 = lat_of(1'b1, u, op2);
    lm = 0;
    if (e0) lm = l0;
    if (e1 && l1 > lm) lm = l1;
    r = res_of(u, op1, op2);
    w = wen_of(u, wa);
    for (int k = 1; k <= lm; k++) begin
      @(negedge clk);
      if (e0 && k <= l0) begin
        chk("val0", cv0, k == l0);
        chk("rdy0", rdy0, k >= l0);
        if (k == l0) begin
          chk("wdata0", cd0, r);
          chk("seq0", cs0, sq);
          chk("waddr0", cw0, wa);
          chk("wen0", ce0, w);
        end
      end
      if (e1 && k <= l1) begin
        chk("val1", cv1, k == l1);
        chk("rdy1", rdy1, k >= l1);
        if (k == l1) begin
          chk("wdata1", cd1, r);
          chk("seq1", cs1, sq);
          chk("waddr1", cw1, wa);
          chk("wen1", ce1, w);
        end
      end
    end
  endtask

  initial begin
    int seen;
    logic [31:0] o1, o2;
    rv_uop u;
    int r;

    rst = 1'b1;
    d_val0 = 1'b0; d_val1 = 1'b0;
    d_pc = '0; d_op1 = '0; d_op2 = '0; d_waddr = '0;
    d_uop = OP_NOP; d_seq_num = '0;

    #12;
    chk("rst_rdy0", rdy0, 1'b0);
    chk("rst_rdy1", rdy1, 1'b0);
    chk("rst_val0", cv0, 1'b0);
    chk("rst_wdata0", cd0, 32'd0);
    chk("rst_seq1", cs1, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_rdy0", rdy0, 1'b1);

    do_op(1, 1, OP_ADD, 32'd5, 32'd7, 5'd3, 5'd2);
    do_op(1, 1, OP_MUL, 32'd6, 32'd7, 5'd4, 5'd1);
    do_op(1, 1, OP_MUL, 32'd3, 32'd5, 5'd8, 5'd3);
    do_op(1, 1, OP_MUL, 32'd9, 32'd0, 5'd9, 5'd4);
    do_op(1, 1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 5'd5);
    do_op(1, 1, OP_ADD, 32'd11, 32'd22, 5'd0, 5'd6);
    do_op(1, 1, OP_LW, 32'd11, 32'd22, 5'd12, 5'd7);
    do_op(1, 1, OP_MUL, 32'h8000_0001, 32'h8000_0000, 5'd13, 5'd8);

    // back-to-back ADDs with d_val held high
    @(negedge clk);
    d_uop = OP_ADD; d_op1 = 32'd1; d_op2 = 32'd2;
    d_waddr = 5'd1; d_seq_num = 5'd0;
    d_val0 = 1'b1; d_val1 = 1'b1;
    @(negedge clk);
    chk("b2b_val_a", cv0, 1'b1);
    chk("b2b_data_a", cd0, 32'd3);
    chk("b2b_seq_a", cs0, 5'd0);
    chk("b2b_data_a1", cd1, 32'd3);
    d_op1 = 32'd3; d_op2 = 32'd4; d_seq_num = 5'd1;
    @(negedge clk);
    d_val0 = 1'b0; d_val1 = 1'b0;
    chk("b2b_val_b", cv0, 1'b1);
    chk("b2b_data_b", cd0, 32'd7);
    chk("b2b_seq_b", cs0, 5'd1);
    chk("b2b_seq_b1", cs1, 5'd1);
    @(negedge clk);
    chk("b2b_idle", cv0, 1'b0);

    // second op held during CALC on the non-early-exit unit
    @(negedge clk);
    d_uop = OP_MUL; d_op1 = 32'd6; d_op2 = 32'd7;
    d_waddr = 5'd4; d_seq_num = 5'd5; d_val0 = 1'b1;
    @(posedge clk);
    #1 d_uop = OP_ADD; d_op1 = 32'd10; d_op2 = 32'd20;
    d_waddr = 5'd6; d_seq_num = 5'd6;
    seen = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (rdy0 || cv0) seen++;
    end
    chk("hold_busy", seen, 0);
    chk("hold_wdata_kept", cd0, 32'd7);
    @(negedge clk);
    chk("hold_val", cv0, 1'b1);
    chk("hold_wdata", cd0, 32'd42);
    chk("hold_seq", cs0, 5'd5);
    chk("hold_wen", ce0, 1'b1);
    chk("hold_rdy", rdy0, 1'b1);
    @(negedge clk);
    d_val0 = 1'b0;
    chk("hold2_val", cv0, 1'b1);
    chk("hold2_wdata", cd0, 32'd30);
    chk("hold2_seq", cs0, 5'd6);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    d_uop = OP_MUL; d_op1 = 32'd7; d_op2 = 32'd7;
    d_waddr = 5'd7; d_seq_num = 5'd9; d_val0 = 1'b1;
    @(posedge clk);
    #1 d_val0 = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_val", cv0, 1'b0);
    chk("arst_wdata", cd0, 32'd0);
    chk("arst_seq", cs0, 5'd0);
    chk("arst_waddr", cw0, 5'd0);
    chk("arst_rdy", rdy0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (cv0) seen++;
    end
    chk("arst_no_done", seen, 0);
    do_op(1, 1, OP_ADD, 32'd2, 32'd2, 5'd5, 5'd3);

    // random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) u = OP_ADD;
      else if (r < 8) u = OP_MUL;
      else if (r == 8) u = OP_LW;
      else u = OP_SW;
      o1 = $urandom();
      o2 = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) o2 = 32'd0;
      do_op(1, 1, u, o1, o2, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_add_execute_unit.md
Name: mul_add_execute_unit

Overview:
- Execute-pipe endpoint on the decode-issue → execute interface.
- Consumes one issued micro-op (pc, op1, op2, waddr, uop, seq_num) via val/rdy.
- Computes ADD in one cycle, or MUL with an iterative radix-2 shift-add multiplier.
- Broadcasts the result on the completion notification bus that feeds back to the decode-issue unit's scoreboard and register file.

Parameters:
- p_seq_num_bits, 5, width of the sequence-number tag carried from issue to completion.
- p_early_exit, 1, when 1 a MUL terminates as soon as the remaining multiplier bits are zero.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- d_val  input  1  issued micro-op valid.
- d_rdy  output  1  unit can accept a micro-op this cycle.
- d_pc  input  32  instruction PC; accepted, not used in computation.
- d_op1  input  32  operand 1.
- d_op2  input  32  operand 2.
- d_waddr  input  5  destination register.
- d_uop  input  rv_uop  micro-op (UArch enum); OP_ADD and OP_MUL are supported.
- d_seq_num  input  p_seq_num_bits  in-flight tag.
- complete_val  output  1  single-cycle completion pulse.
- complete_seq_num  output  p_seq_num_bits  tag of the completing op.
- complete_waddr  output  5  destination register.
- complete_wdata  output  32  result.
- complete_wen  output  1  register write enable.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - complete_val=0; all complete_* fields=0.
  - Internal a/b/acc/count registers=0.
  - d_rdy=0 while rst is asserted.
- States:
  - IDLE: d_rdy=1, complete_val=0.
  - CALC: d_rdy=0, complete_val=0.
  - DONE: d_rdy=1, complete_val=1.
- Handshake: a transfer happens on a posedge where d_val&d_rdy. Fields are captured only on transfer. d_val without d_rdy has no effect.
- On accept, latch seq_num and waddr.
  - wen = (d_waddr != 0) && (d_uop is ADD or MUL).
- OP_ADD: wdata = (op1 + op2) mod 2^32. Next state is DONE, so completion is visible in the cycle after accept (latency 1).
- OP_MUL setup on accept: a=op1, b=op2, acc=0, count=0.
  - If p_early_exit and op2==0: next state is DONE with wdata=0.
  - Otherwise next state is CALC.
- CALC, one iteration per cycle:
  - If b[0], acc += a (mod 2^32).
  - a <<= 1; b >>= 1; count++.
  - Go to DONE after iteration 32 (count==31 before the update), or, if p_early_exit, when the updated b==0.
  - wdata = final acc, i.e. the low 32 bits of the unsigned product (same as signed).
- MUL latency:
  - Without early exit: CALC occupies 32 cycles and completion appears at T+33.
  - With early exit: cycles = index of the highest set bit of op2 plus 1; completion appears at T+cycles+1.
- Any other uop: accepted, completes with latency 1, wdata=0, wen=0.
- DONE lasts exactly one cycle; the completion bus has no backpressure.
  - If a transfer occurs in DONE, the next state follows the new op's rules (back-to-back, no bubble). Otherwise the next state is IDLE.
- Outside DONE: complete_val=0, and the complete_* fields hold their last values.
- Reset asserted mid-CALC: the op is aborted and no completion is ever produced for it.
- count is 5 bits; it never wraps within an op because it is cleared on each accept.

Test Plan:
- ADD, op1=5, op2=7, waddr=3, seq=2, accepted at T → complete_val=1 only at T+1, wdata=12, waddr=3, seq=2, wen=1. d_rdy=1 throughout.
- p_early_exit=0, MUL 6×7, waddr=4 → d_rdy=0 for 32 cycles, complete at T+33, wdata=42, wen=1. A second d_val held during CALC is not accepted until DONE.
- p_early_exit=1:
  - MUL 3×5 → complete at T+4, wdata=15.
  - MUL 9×0 → complete at T+1, wdata=0.
  - MUL 0xFFFFFFFF×0xFFFFFFFF → complete at T+33, wdata=0x00000001.
- ADD to waddr=0 → complete_val=1, wen=0. Unsupported uop (OP_LW) → complete_val=1, wdata=0, wen=0.
- Back-to-back: ADD(1,2,seq=0) then ADD(3,4,seq=1) with d_val held → completions on consecutive cycles, wdata 3 then 7, seq 0 then 1.
- MUL 7×7 accepted, rst pulsed asynchronously at T+5 → outputs 0 immediately, no completion for seq. A subsequent ADD(2,2) completes normally with wdata=4.
